return_addr_stack: RTL and testbench
====================================

// Module: return_addr_stack
// PURPOSE
//  Clocked, parametrised return-address stack for the MIPS core; stores JAL return addresses, pops on JS.
//  Keeps its own storage, entry count and stack-pointer address.
//  Adds registered state, full/empty status, sticky overflow/underflow errors, flush and push+pop replace.
//  Sits beside the PC-select logic: decode drives push/pop, PC mux consumes top_data.
// PARAMETERS
//  WIDTH      32        bits per stored return address
//  DEPTH      9         number of entries (>=2)
//  BASE_ADDR  32'h58    sp_addr value when stack is empty
//  ADDR_STEP  4         sp_addr increment per stored entry
// PORTS
//  clk        in   1                    single clock, all state updates on rising edge
//  rst_n      in   1                    synchronous, active-low reset
//  flush      in   1                    discard all entries (pipeline redirect)
//  push       in   1                    JAL: store push_data
//  pop        in   1                    JS: remove top entry
//  push_data  in   WIDTH                return address to store (PC+4)
//  clr_err    in   1                    clear sticky overflow/underflow
//  top_data   out  WIDTH                current top entry; 0 when empty
//  sp_addr    out  32                   BASE_ADDR + ADDR_STEP*count
//  count      out  $clog2(DEPTH+1)      entries held, 0..DEPTH
//  empty      out  1                    count==0
//  full       out  1                    count==DEPTH
//  overflow   out  1                    sticky: push attempted while full
//  underflow  out  1                    sticky: pop attempted while empty
// BEHAVIOUR
//  - Reset (rst_n==0 at edge): count=0, overflow=0, underflow=0, sp_addr=BASE_ADDR, empty=1, full=0, top_data=0; storage not cleared.
//  - top_data, empty, full, sp_addr: combinational from registered state; a push is visible on top_data the cycle after the edge.
//  - Priority per edge: rst_n > flush > push/pop. flush: count=0, error flags unchanged.
//  - push only, not full: write push_data at index count, count+1.
//  - pop only, not empty: count-1; popped value is the top_data presented in that cycle.
//  - push & pop, not empty: overwrite top entry with push_data, count unchanged, no flags.
//  - push & pop, empty: treated as push only; underflow not set.
//  - pop while empty: no state change, underflow<=1.
//  - push while full: see CONFIGURATION; overflow<=1 in both modes.
//  - clr_err: clears both flags; a new error in the same cycle wins (flag stays 1).
//  - count never exceeds DEPTH nor wraps below 0; sp_addr 32-bit unsigned, no saturation needed.
// CONFIGURATION
//  RAS_WRAP_EN defined: circular storage with base index; push while full overwrites the oldest entry,
//    base index advances mod DEPTH, count stays DEPTH, new value becomes top; overflow<=1.
//  RAS_WRAP_EN undefined: linear storage; push while full dropped, contents and count unchanged; overflow<=1.
// TESTING (DEPTH=9, BASE_ADDR=32'h58)
//  - Reset then idle -> count=0, sp_addr=32'h58, empty=1, top_data=0, flags 0.
//  - Push 32'h100,32'h104..32'h120 (9 pushes) -> full=1, sp_addr=32'h7C, top_data=32'h120; 9 pops return reverse order, final sp_addr=32'h58.
//  - Pop when empty -> underflow=1, count=0; clr_err -> underflow=0 next cycle.
//  - Full, push 32'h200 -> overflow=1; no WRAP: top=32'h120, count 9; WRAP: top=32'h200, 9 pops end with 32'h104.
//  - count=3, top 32'h10C, push&pop with 32'hABC -> count=3, top_data=32'hABC; push&pop when empty -> count=1.
//  - count=5, flush with push asserted -> count=0, empty=1; rst_n low mid-sequence -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/return_addr_stack.sv
// Return-address stack: JAL pushes PC+4, JS pops. Registered count, full/empty
// status, sticky overflow/underflow, flush and push+pop replace.
// Optional feature macro: RAS_WRAP_EN (circular storage, push-while-full
// overwrites the oldest entry). Without it a push while full is dropped.
module return_addr_stack #(
  parameter int          WIDTH     = 32,
  parameter int          DEPTH     = 9,
  parameter logic [31:0] BASE_ADDR = 32'h58,
  parameter int          ADDR_STEP = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           top_data,
  output logic [31:0]                sp_addr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [CW:0]   DEPTH_X = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [IW-1:0] LAST_I  = IW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count_q, count_n;
  logic [IW-1:0]    base_q, base_n;
  logic             ovf_q, unf_q, ovf_set, unf_set;
  logic             we;
  logic [IW-1:0]    widx, top_idx, wr_idx;

  // Fold a logical position (base + offset, < 2*DEPTH) back into storage range.
  function automatic logic [IW-1:0] phys(input logic [CW:0] pos);
    logic [CW:0] r;
    r = (pos >= DEPTH_X) ? pos - DEPTH_X : pos;
    return r[IW-1:0];
  endfunction

  // Storage positions of the current top and the next free slot. In linear
  // mode base stays 0, so these reduce to count-1 and count.
  always_comb begin
    top_idx = phys((CW+1)'(base_q) + {1'b0, count_q} - (CW+1)'(1));
    wr_idx  = phys((CW+1)'(base_q) + {1'b0, count_q});
  end

  // Status outputs derived from registered state.
  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == DEPTH_C);
    count     = count_q;
    overflow  = ovf_q;
    underflow = unf_q;
    sp_addr   = BASE_ADDR + 32'(ADDR_STEP) * 32'(count_q);
    top_data  = empty ? '0 : mem[top_idx];
  end

  // Next-state decode: flush beats push/pop; push+pop on a non-empty stack
  // becomes an in-place replace of the top entry.
  always_comb begin
    count_n = count_q;
    base_n  = base_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    we      = 1'b0;
    widx    = wr_idx;
    if (!rst_n) begin
      we = 1'b0;
    end else if (flush) begin
      count_n = '0;
    end else if (push && pop && !empty) begin
      we   = 1'b1;
      widx = top_idx;
    end else if (push) begin
      if (!full) begin
        we      = 1'b1;
        count_n = count_q + CW'(1);
      end else begin
        ovf_set = 1'b1;
`ifdef RAS_WRAP_EN
        // Full: the slot after the top is the oldest entry; overwrite it
        // and advance base so the new value becomes the top.
        we     = 1'b1;
        base_n = (base_q == LAST_I) ? '0 : base_q + IW'(1);
`endif
      end
    end else if (pop) begin
      if (!empty) count_n = count_q - CW'(1);
      else        unf_set = 1'b1;
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      base_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_n;
      base_q  <= base_n;
      ovf_q   <= ovf_set | (ovf_q & ~clr_err);
      unf_q   <= unf_set | (unf_q & ~clr_err);
    end
  end

  // Entry storage; deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[widx] <= push_data;
  end

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed self-checking bench for return_addr_stack (DEPTH=9, BASE_ADDR=0x58).
module tb_return_addr_stack;

  logic        clk = 1'b0;
  logic        rst_n, flush, push, pop, clr_err;
  logic [31:0] push_data;
  logic [31:0] top_data, sp_addr;
  logic [3:0]  count;
  logic        empty, full, overflow, underflow;

  int tests = 0;
  int fails = 0;

  return_addr_stack #(
    .WIDTH(32), .DEPTH(9), .BASE_ADDR(32'h58), .ADDR_STEP(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .push(push), .pop(pop),
    .push_data(push_data), .clr_err(clr_err), .top_data(top_data),
    .sp_addr(sp_addr), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge with the currently driven inputs, then return to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    flush = 0; push = 0; pop = 0; clr_err = 0; push_data = '0;
  endtask

  task automatic do_push(input logic [31:0] d);
    push = 1; push_data = d; tick();
  endtask

  task automatic do_pop();
    pop = 1; tick();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_sp"}, sp_addr, 32'h58);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_top"}, top_data, 32'h0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
    check({tag, "_unf"}, 32'(underflow), 32'd0);
  endtask

  initial begin
    rst_n = 0; flush = 0; push = 0; pop = 0; clr_err = 0; push_data = '0;
    @(posedge clk); #1;
    tick();
    rst_n = 1;
    tick();
    check_reset("rst");

    // Fill to DEPTH.
    for (int i = 0; i < 9; i++) begin
      do_push(32'h100 + 32'(4 * i));
      check("fill_top", top_data, 32'h100 + 32'(4 * i));
    end
    check("fill_full", 32'(full), 32'd1);
    check("fill_sp", sp_addr, 32'h7C);
    check("fill_count", 32'(count), 32'd9);
    check("fill_empty", 32'(empty), 32'd0);

    // Push while full.
    do_push(32'h200);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd9);
`ifdef RAS_WRAP_EN
    check("ovf_top", top_data, 32'h200);
    for (int i = 0; i < 9; i++) begin
      check("drain_top", top_data, (i == 0) ? 32'h200 : 32'h120 - 32'(4 * (i - 1)));
      do_pop();
    end
`else
    check("ovf_top", top_data, 32'h120);
    for (int i = 0; i < 9; i++) begin
      check("drain_top", top_data, 32'h120 - 32'(4 * i));
      do_pop();
    end
`endif
    check("drain_sp", sp_addr, 32'h58);
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_top0", top_data, 32'h0);
    check("ovf_sticky", 32'(overflow), 32'd1);
    clr_err = 1; tick();
    check("ovf_clr", 32'(overflow), 32'd0);

    // Underflow, clear, and clear racing a new error.
    do_pop();
    check("unf_flag", 32'(underflow), 32'd1);
    check("unf_count", 32'(count), 32'd0);
    clr_err = 1; tick();
    check("unf_clr", 32'(underflow), 32'd0);
    clr_err = 1; pop = 1; tick();
    check("unf_clr_race", 32'(underflow), 32'd1);
    clr_err = 1; tick();
    check("unf_clr2", 32'(underflow), 32'd0);

    // Push+pop replace on a non-empty stack.
    do_push(32'h104); do_push(32'h108); do_push(32'h10C);
    check("rep_pre_top", top_data, 32'h10C);
    push = 1; pop = 1; push_data = 32'hABC; tick();
    check("rep_count", 32'(count), 32'd3);
    check("rep_top", top_data, 32'hABC);
    check("rep_flags", {30'd0, overflow, underflow}, 32'd0);
    do_pop();
    check("rep_pop_top", top_data, 32'h108);
    check("rep_pop_count", 32'(count), 32'd2);

    // Flush wins over a simultaneous push.
    do_push(32'h300); do_push(32'h304); do_push(32'h308);
    check("fl_pre_count", 32'(count), 32'd5);
    flush = 1; push = 1; push_data = 32'h999; tick();
    check("fl_count", 32'(count), 32'd0);
    check("fl_empty", 32'(empty), 32'd1);
    check("fl_top", top_data, 32'h0);

    // Push+pop on an empty stack acts as a push without underflow.
    push = 1; pop = 1; push_data = 32'h55; tick();
    check("pp_empty_count", 32'(count), 32'd1);
    check("pp_empty_top", top_data, 32'h55);
    check("pp_empty_unf", 32'(underflow), 32'd0);

    // Reset mid-sequence with an error flag set.
    do_push(32'h60); do_push(32'h64);
    pop = 1; tick(); pop = 1; tick(); pop = 1; tick(); pop = 1; tick();
    check("pre_rst_unf", 32'(underflow), 32'd1);
    do_push(32'h70);
    rst_n = 0; push = 1; push_data = 32'h74; tick();
    check_reset("mid_rst");
    rst_n = 1;
    do_push(32'h80);
    check("post_rst_top", top_data, 32'h80);
    check("post_rst_sp", sp_addr, 32'h5C);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
